// File: rtl/spi_master_ctrl_if.sv
// User-side handshake bundle for spi_master_ctrl.
//   start   : request a transfer (sampled only while the controller is idle)
//   tx_data : word sent to the slave, captured on the accepted start
//   rx_data : word received from the slave, valid from done until next start
//   busy    : transfer in progress
//   done    : one-cycle end-of-transfer pulse
// modport master = requester side, modport slave = controller side.
interface spi_master_ctrl_if #(
  parameter int unsigned WIDTH = 13
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;

  modport master (output start, output tx_data,
                  input  rx_data, input busy, input done);
  modport slave  (input  start, input tx_data,
                  output rx_data, output busy, output done);
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master driving one spi_slave: WIDTH-bit full-duplex frame, MSB first.
// Sequence per frame: load pulse (slave captures its din), WIDTH sclk
// periods, load pulse (slave presents the received word on dout).
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   bus            : start/tx_data/rx_data/busy/done handshake (slave modport)
//   o_spi_sclk     : serial clock to slave, idles low
//   o_spi_mosi     : serial data to slave, holds last bit when idle
//   o_spi_load     : load strobe to slave
//   i_spi_miso     : serial data from slave
// All outputs come straight from flops since the slave treats sclk and load
// as clocks.
module spi_master_ctrl #(
  parameter int unsigned WIDTH   = 13,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  spi_master_ctrl_if.slave   bus,
  output logic               o_spi_sclk,
  output logic               o_spi_mosi,
  output logic               o_spi_load,
  input  logic               i_spi_miso
);

  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_SHIFT,
    S_POSTLOAD,
    S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [DIV_W-1:0]   r_div,   w_div;
  logic [BIT_W-1:0]   r_bit,   w_bit;
  logic [WIDTH-1:0]   r_tx,    w_tx;
  logic [WIDTH-1:0]   r_rx,    w_rx;
  logic [WIDTH-1:0]   r_rx_data, w_rx_data;
  logic               r_busy,  w_busy;
  logic               r_done,  w_done;
  logic               r_sclk,  w_sclk;
  logic               r_mosi,  w_mosi;
  logic               r_load,  w_load;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_div     <= w_div;
      r_bit     <= w_bit;
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_rx_data <= w_rx_data;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
      r_load    <= w_load;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state   = r_state;
    w_div     = r_div;
    w_bit     = r_bit;
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_rx_data = r_rx_data;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;
    w_load    = r_load;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_tx    = bus.tx_data;
          w_rx    = '0;
          w_busy  = 1'b1;
          w_div   = '0;
          w_state = S_PRELOAD;
        end
      end

      // First cycle here raises load; load then stays up for CLK_DIV cycles.
      S_PRELOAD: begin
        if (r_div == DIV_FULL) begin
          w_load  = 1'b0;
          w_div   = '0;
          w_bit   = '0;
          w_mosi  = r_tx[WIDTH-1];
          w_state = S_SHIFT;
        end else begin
          w_load = 1'b1;
          w_div  = r_div + DIV_W'(1);
        end
      end

      // Each half-period lasts CLK_DIV cycles; act at the end of each half.
      S_SHIFT: begin
        if (r_div != DIV_LAST) begin
          w_div = r_div + DIV_W'(1);
        end else begin
          w_div = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
            w_rx   = {r_rx[WIDTH-2:0], i_spi_miso};
          end else begin
            w_sclk = 1'b0;
            w_tx   = {r_tx[WIDTH-2:0], 1'b0};
            if (r_bit == BIT_LAST) begin
              // mosi keeps the final bit; load rises as sclk falls
              w_load  = 1'b1;
              w_state = S_POSTLOAD;
            end else begin
              w_bit  = r_bit + BIT_W'(1);
              w_mosi = r_tx[WIDTH-2];
            end
          end
        end
      end

      S_POSTLOAD: begin
        if (r_div == DIV_LAST) begin
          w_load    = 1'b0;
          w_div     = '0;
          w_rx_data = r_rx;
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_state   = S_DONE;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.rx_data = r_rx_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign o_spi_sclk  = r_sclk;
  assign o_spi_mosi  = r_mosi;
  assign o_spi_load  = r_load;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: two controllers (CLK_DIV=2 and
// CLK_DIV=1), each attached to a behavioural spi_slave model. Expected data
// and latency come from the frame rules: the master must receive the slave's
// din, the slave must receive tx_data, and done arrives 2*D*(W+1)+1 cycles
// after the accepted start.
module tb_spi_master_ctrl;

  localparam int unsigned W  = 13;
  localparam int unsigned D0 = 2;
  localparam int unsigned D1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic sclk0, mosi0, load0, miso0;
  logic sclk1, mosi1, load1, miso1;

  int passed = 0;
  int total  = 0;

  spi_master_ctrl_if #(.WIDTH(W)) b0 ();
  spi_master_ctrl_if #(.WIDTH(W)) b1 ();

  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(D0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave),
    .o_spi_sclk(sclk0), .o_spi_mosi(mosi0), .o_spi_load(load0), .i_spi_miso(miso0)
  );

  spi_master_ctrl #(.WIDTH(W), .CLK_DIV(D1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave),
    .o_spi_sclk(sclk1), .o_spi_mosi(mosi1), .o_spi_load(load1), .i_spi_miso(miso1)
  );

  always #5 clk = ~clk;

  // Behavioural slaves: load captures din and publishes the received word,
  // sclk rise shifts mosi in, sclk fall presents the next bit on miso.
  logic [W-1:0] s0_din = '0, s0_sr = '0, s0_dout = '0;
  logic [W-1:0] s1_din = '0, s1_sr = '0, s1_dout = '0;
  logic         s0_miso = 1'b0, s1_miso = 1'b0;

  always @(posedge sclk0 or posedge load0) begin
    if (load0) begin
      s0_dout <= s0_sr;
      s0_sr   <= s0_din;
    end else begin
      s0_sr <= {s0_sr[W-2:0], mosi0};
    end
  end
  always @(negedge sclk0 or posedge load0) begin
    if (load0) s0_miso <= s0_din[W-1];
    else       s0_miso <= s0_sr[W-1];
  end

  always @(posedge sclk1 or posedge load1) begin
    if (load1) begin
      s1_dout <= s1_sr;
      s1_sr   <= s1_din;
    end else begin
      s1_sr <= {s1_sr[W-2:0], mosi1};
    end
  end
  always @(negedge sclk1 or posedge load1) begin
    if (load1) s1_miso <= s1_din[W-1];
    else       s1_miso <= s1_sr[W-1];
  end

  assign miso0 = s0_miso;
  assign miso1 = s1_miso;

  // Event monitors
  int rises0 = 0, loads0 = 0, dones0 = 0;
  int rises1 = 0, loads1 = 0, dones1 = 0;
  int overlap = 0;
  always @(posedge sclk0) rises0 <= rises0 + 1;
  always @(posedge load0) loads0 <= loads0 + 1;
  always @(posedge sclk1) rises1 <= rises1 + 1;
  always @(posedge load1) loads1 <= loads1 + 1;
  always @(posedge clk) begin
    if (b0.done) dones0 <= dones0 + 1;
    if (b1.done) dones1 <= dones1 + 1;
  end
  always @(negedge clk) begin
    if ((sclk0 && load0) || (sclk1 && load1)) overlap <= overlap + 1;
  end

  function automatic int exp_lat(input int d);
    return 2 * int'(d == 0 ? D0 : D1) * int'(W + 1) + 1;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? b0.done : b1.done;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? b0.busy : b1.busy;
  endfunction

  function automatic logic [W-1:0] get_rx(input int d);
    return (d == 0) ? b0.rx_data : b1.rx_data;
  endfunction

  function automatic logic [W-1:0] get_sdout(input int d);
    return (d == 0) ? s0_dout : s1_dout;
  endfunction

  function automatic int get_rises(input int d);
    return (d == 0) ? rises0 : rises1;
  endfunction

  function automatic int get_loads(input int d);
    return (d == 0) ? loads0 : loads1;
  endfunction

  function automatic logic [W+4:0] get_outs(input int d);
    if (d == 0) return {sclk0, mosi0, load0, b0.busy, b0.done, b0.rx_data};
    return {sclk1, mosi1, load1, b1.busy, b1.done, b1.rx_data};
  endfunction

  task automatic drive(input int d, input logic s, input logic [W-1:0] tx);
    if (d == 0) begin b0.start = s; b0.tx_data = tx; end
    else        begin b1.start = s; b1.tx_data = tx; end
  endtask

  task automatic set_din(input int d, input logic [W-1:0] v);
    if (d == 0) s0_din = v; else s1_din = v;
  endtask

  // Runs one frame from an idle controller and reports what was observed.
  // Entered and left #1 after a rising edge with the controller idle.
  // glitch > 0 pulses start with 13'h1FFF that many cycles into the frame.
  task automatic run_frame(input int d, input logic [W-1:0] tx, input logic [W-1:0] din,
                           input int glitch, output int lat, output logic [W-1:0] rx,
                           output logic [W-1:0] sdout, output int nrise, output int nload,
                           output logic busy_start, output logic busy_done);
    int r0, l0, n;
    r0 = get_rises(d);
    l0 = get_loads(d);
    set_din(d, din);
    drive(d, 1'b1, tx);
    @(posedge clk); #1;
    drive(d, 1'b0, tx);
    busy_start = get_busy(d);
    lat = -1;
    n   = 0;
    while (lat < 0 && n < 400) begin
      @(posedge clk); n++; #1;
      if (get_done(d))      lat = n;
      else if (n == glitch) drive(d, 1'b1, 13'h1FFF);
      else                  drive(d, 1'b0, tx);
    end
    rx        = get_rx(d);
    sdout     = get_sdout(d);
    nrise     = get_rises(d) - r0;
    nload     = get_loads(d) - l0;
    busy_done = get_busy(d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int r0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (get_outs(d) !== '0) $display("FAIL reset_outs dut%0d: got %h expected 0", d, get_outs(d));
      else passed++;
    end
    r0 = rises0 + rises1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (rises0 + rises1 != r0 || get_outs(0) !== '0 || get_outs(1) !== '0)
      $display("FAIL reset_hold: sclk rises %0d outs %h/%h expected 0 rises and zero outs",
               rises0 + rises1 - r0, get_outs(0), get_outs(1));
    else passed++;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (rises0 + rises1 != r0 || b0.busy !== 1'b0 || b1.busy !== 1'b0)
      $display("FAIL idle_quiet: sclk rises %0d busy %b%b expected 0 and 00",
               rises0 + rises1 - r0, b0.busy, b1.busy);
    else passed++;
  endtask

  task automatic test_single();
    int lat, nr, nl;
    logic [W-1:0] rx, sd;
    logic bs, bd;
    run_frame(0, 13'h1A5B, 13'h0F0F, 0, lat, rx, sd, nr, nl, bs, bd);
    total++;
    if (lat != exp_lat(0)) $display("FAIL single_lat: got %0d expected %0d", lat, exp_lat(0));
    else passed++;
    total++;
    if (rx !== 13'h0F0F) $display("FAIL single_rx: got %h expected 0f0f", rx);
    else passed++;
    total++;
    if (sd !== 13'h1A5B) $display("FAIL single_slave_dout: got %h expected 1a5b", sd);
    else passed++;
    total++;
    if (nr != int'(W) || nl != 2) $display("FAIL single_edges: rises %0d loads %0d expected %0d and 2", nr, nl, W);
    else passed++;
    total++;
    if (bs !== 1'b1 || bd !== 1'b0) $display("FAIL single_busy: start %b done %b expected 1 and 0", bs, bd);
    else passed++;
  endtask

  task automatic test_boundary();
    logic [W-1:0] txs [6];
    logic [W-1:0] dns [6];
    int lat, nr, nl;
    logic [W-1:0] rx, sd;
    logic bs, bd;
    txs = '{13'h1FFF, 13'h0000, 13'h1FFF, 13'h0000, 13'h0AAA, 13'h1555};
    dns = '{13'h0000, 13'h1FFF, 13'h1FFF, 13'h0000, 13'h1555, 13'h0AAA};
    for (int i = 0; i < 6; i++) begin
      run_frame(1, txs[i], dns[i], 0, lat, rx, sd, nr, nl, bs, bd);
      total++;
      if (lat != exp_lat(1) || rx !== dns[i] || sd !== txs[i])
        $display("FAIL boundary_%0d: lat %0d rx %h slave %h expected lat %0d rx %h slave %h",
                 i, lat, rx, sd, exp_lat(1), dns[i], txs[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int lat, nr, nl;
    logic [W-1:0] rx, sd, tx, din;
    logic bs, bd;
    for (int i = 0; i < 8; i++) begin
      tx  = W'($urandom);
      din = W'($urandom);
      run_frame(i % 2, tx, din, 0, lat, rx, sd, nr, nl, bs, bd);
      total++;
      if (lat != exp_lat(i % 2) || rx !== din || sd !== tx || nr != int'(W) || nl != 2)
        $display("FAIL random_%0d: lat %0d rx %h slave %h rises %0d loads %0d expected %0d %h %h %0d 2",
                 i, lat, rx, sd, nr, nl, exp_lat(i % 2), din, tx, W);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] tv [3];
    logic [W-1:0] dv [3];
    int n;
    logic got;
    for (int i = 0; i < 3; i++) begin
      tv[i] = W'($urandom);
      dv[i] = W'($urandom);
    end
    tv[1] = ~tv[0];
    dv[1] = ~dv[0];
    s0_din = dv[0];
    drive(0, 1'b1, tv[0]);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n   = 0;
      got = 1'b0;
      while (!got && n < 400) begin
        @(posedge clk); n++; #1;
        if (b0.done) got = 1'b1;
      end
      total++;
      if (!got || n != exp_lat(0)) $display("FAIL b2b_lat_%0d: got %0d expected %0d", k, n, exp_lat(0));
      else passed++;
      total++;
      if (b0.rx_data !== dv[k] || s0_dout !== tv[k])
        $display("FAIL b2b_data_%0d: rx %h slave %h expected %h %h", k, b0.rx_data, s0_dout, dv[k], tv[k]);
      else passed++;
      if (k < 2) begin
        drive(0, 1'b1, tv[k+1]);
        s0_din = dv[k+1];
        @(posedge clk); #1;
        total++;
        if (b0.busy !== 1'b0 || b0.done !== 1'b0)
          $display("FAIL b2b_idle_%0d: busy %b done %b expected 0 0", k, b0.busy, b0.done);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (b0.busy !== 1'b1) $display("FAIL b2b_restart_%0d: busy %b expected 1", k, b0.busy);
        else passed++;
      end else begin
        drive(0, 1'b0, tv[k]);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_start_busy();
    int lat, nr, nl, d0;
    logic [W-1:0] rx, sd, tx, din;
    logic bs, bd;
    tx  = W'($urandom) & 13'h0FFF;
    din = W'($urandom);
    d0  = dones0;
    run_frame(0, tx, din, 20, lat, rx, sd, nr, nl, bs, bd);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (lat != exp_lat(0) || rx !== din || sd !== tx)
      $display("FAIL start_busy: lat %0d rx %h slave %h expected %0d %h %h", lat, rx, sd, exp_lat(0), din, tx);
    else passed++;
    total++;
    if (dones0 - d0 != 1 || b0.busy !== 1'b0)
      $display("FAIL start_busy_extra: done pulses %0d busy %b expected 1 and 0", dones0 - d0, b0.busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int r0, d0, n, lat, nr, nl;
    logic [W-1:0] rx, sd, din;
    logic bs, bd;
    r0 = rises0;
    d0 = dones0;
    s0_din = W'($urandom);
    drive(0, 1'b1, W'($urandom));
    @(posedge clk); #1;
    drive(0, 1'b0, 13'h0);
    n = 0;
    while (rises0 - r0 < 5 && n < 300) begin
      @(posedge clk); n++; #1;
    end
    total++;
    if (rises0 - r0 != 5) $display("FAIL reset_mid_reach: rises %0d expected 5", rises0 - r0);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (get_outs(0) !== '0) $display("FAIL reset_mid_outs: got %h expected 0", get_outs(0));
    else passed++;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    total++;
    if (dones0 != d0 || b0.busy !== 1'b0) $display("FAIL reset_mid_done: pulses %0d busy %b expected 0 0", dones0 - d0, b0.busy);
    else passed++;
    din = W'($urandom);
    run_frame(0, 13'h0123, din, 0, lat, rx, sd, nr, nl, bs, bd);
    total++;
    if (lat != exp_lat(0) || rx !== din || sd !== 13'h0123)
      $display("FAIL reset_mid_next: lat %0d rx %h slave %h expected %0d %h 0123", lat, rx, sd, exp_lat(0), din);
    else passed++;
  endtask

  task automatic test_protocol();
    total++;
    if (overlap != 0) $display("FAIL sclk_load_overlap: got %0d cycles expected 0", overlap);
    else passed++;
  endtask

  initial begin
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_boundary();
    test_random();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Clocked SPI master that drives one `spi_slave` instance (WIDTH-bit full-duplex shift, MSB first). It sits directly upstream of the slave: it generates `sclk`, `mosi` and the `load` strobe, and samples `miso`. A transfer parallel-loads the slave's transmit word, shifts WIDTH bits each way, then strobes `load` again so the slave's `dout` presents the received word. The user side is a start/busy/done handshake on the system clock. The slave's `clr` input is tied low at top level and is not driven by this block.

## Interface
- `WIDTH`, 13, frame length in bits; must match the slave.
- `CLK_DIV`, 2, system clocks per `sclk` half-period; minimum 1.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `tx_data`  in  WIDTH  word for the slave; captured on the accepted `start`.
- `rx_data`  out  WIDTH  word shifted in from `miso`; valid from `done` until the next accepted `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `spi_sclk`  out  1  to slave `sclk`; idles low.
- `spi_mosi`  out  1  to slave `mosi`.
- `spi_load`  out  1  to slave `load`.
- `spi_miso`  in  1  from slave `miso`.

## Operation
- All outputs are registered and glitch-free, because the slave uses `spi_load` and `spi_sclk` as edge-sensitive clocks.
- Reset values: `spi_sclk=0`, `spi_mosi=0`, `spi_load=0`, `busy=0`, `done=0`, `rx_data=0`, FSM in IDLE, counters 0.
- FSM states:
  - IDLE: if `start`, latch `tx_data` into the TX shift register, clear the RX shift register, set `busy`, and go to PRELOAD.
  - PRELOAD: hold `spi_load=1` for CLK_DIV cycles. The slave loads its `din` on the rising edge, so `miso` then shows the slave's word MSB. Go to SHIFT.
  - SHIFT: runs WIDTH bit periods, each CLK_DIV cycles with `sclk` low followed by CLK_DIV cycles with `sclk` high.
    - On entry to each low phase, drive `spi_mosi` with the TX register MSB.
    - On the cycle `spi_sclk` goes high, sample `spi_miso` into the RX register LSB (shift left).
    - On the cycle `spi_sclk` falls, shift the TX register left.
    - After the WIDTH-th high phase, `spi_sclk` returns low and the FSM goes to POSTLOAD.
  - POSTLOAD: hold `spi_load=1` for CLK_DIV cycles, so the slave sets `dout` to the received word. Then drop `spi_load`, copy the RX register to `rx_data`, and go to DONE.
  - DONE: `done=1` for one cycle, `busy=0`, return to IDLE.
- `spi_load` and `spi_sclk` are never high in the same cycle.
- `start` while `busy` is ignored. `start` held continuously starts back-to-back frames, with one IDLE cycle between them.
- `spi_mosi` holds its last bit when idle.
- Bit counter width is clog2(WIDTH+1). Divider counter width is clog2(CLK_DIV+1). Neither counter wraps mid-frame.
- Reset asserted mid-frame aborts immediately: all outputs return to reset values and the partial frame is discarded. The slave is left in an arbitrary shift state; the next frame's PRELOAD resynchronises it.

## Timing
- Accepted `start` is at edge 0.
- `spi_load` is high for edges 1..D, where D = CLK_DIV.
- The first `spi_sclk` rise is at edge 2D+1.
- `done` is high in the cycle after edge 2D(WIDTH+1), i.e. total latency is 2D(WIDTH+1)+1 cycles (57 for the defaults).
- `sclk` frequency is f_clk/(2·CLK_DIV).
- `mosi` is stable for D cycles before each `sclk` rise. The slave updates `miso` on `sclk` fall, which gives D cycles of setup before the master's sample.
- `rx_data` updates on the same edge `done` rises.

## Test plan
- Reset and idle, with a behavioural `spi_slave` model attached: assert `rst_n=0` mid-idle. All outputs must be 0, and no `sclk` edges occur while `start=0`.
- Single frame, defaults: `tx_data=13'h1A5B`, slave `din=13'h0F0F`.
  - `done` must pulse exactly 57 cycles after start.
  - `rx_data=13'h0F0F`.
  - Slave `dout=13'h1A5B`.
  - Exactly 13 `sclk` rises and 2 `load` pulses.
- Boundary patterns with CLK_DIV=1: all-ones and all-zeros each way, then alternating `13'h0AAA`/`13'h1555`. Data must match and latency must be 29.
- Back-to-back: `start` held high for 3 frames with different `tx_data`. Each `done` must be followed by a new frame after one IDLE cycle, with no data carried over between frames.
- `start` while busy: pulse `start` with `tx_data=13'h1FFF` mid-SHIFT. It must be ignored, and the current frame's data must be unchanged.
- Reset mid-frame: drop `rst_n` after 5 `sclk` rises. Outputs must go to 0 immediately and `done` must never fire. A following frame with `tx_data=13'h0123` must transfer correctly.
